// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller blocks.
// Provides debounce count defaults, the idle level of an active-low button,
// the debounced button state type and a helper that maps button polarity
// to its idle level.
package tlc_pkg;

   // Debounce qualification counts: short for simulation, 10 ms at 100 MHz on the board.
   localparam int DEBOUNCE_CYCLES_SIM = 4;
   localparam int DEBOUNCE_CYCLES_HW  = 1_000_000;

   // Level an active-low button rests at when nobody touches it.
   localparam logic BTN_IDLE_ACTIVE_LOW = 1'b1;

   typedef enum logic {
      DB_RELEASED = 1'b0,
      DB_PRESSED  = 1'b1
   } db_state_e;

   // Idle (released) level of the raw button for a given polarity setting.
   function automatic logic btn_idle_level(input int active_low);
      return (active_low != 0) ? BTN_IDLE_ACTIVE_LOW : ~BTN_IDLE_ACTIVE_LOW;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk_i  - destination clock, rising edge
//   rst_ni - asynchronous active-low reset; both flops load RST_VAL
//   d_i    - asynchronous input level
//   q_o    - synchronised level, two clock edges behind d_i
module sync_2ff
   import tlc_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic ff1_q;
   logic ff2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ff1_q <= RST_VAL;
         ff2_q <= RST_VAL;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
      end
   end

   assign q_o = ff2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchronises a raw bouncing button, qualifies
// each level change over STABLE_CYCLES consecutive samples, and emits one
// single-cycle pulse per debounced press (nothing on release, no repeat).
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   btn       - raw asynchronous button level, may bounce
//   btn_pulse - registered one-clock pulse per debounced press
module debounce_pulse
   import tlc_pkg::*;
#(
   parameter int STABLE_CYCLES  = DEBOUNCE_CYCLES_SIM,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic btn_pulse
);

   localparam logic IDLE_LVL = btn_idle_level(BTN_ACTIVE_LOW);
   localparam int   CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic            btn_s;
   db_state_e       samp_state;
   db_state_e       db_state_q, db_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            pulse_q, pulse_d;

   // Synchroniser resets to the idle level so reset release never looks like a press.
   sync_2ff #(
      .RST_VAL(IDLE_LVL)
   ) u_sync_btn (
      .clk_i (clk),
      .rst_ni(rst),
      .d_i   (btn),
      .q_o   (btn_s)
   );

   assign samp_state = (btn_s == IDLE_LVL) ? DB_RELEASED : DB_PRESSED;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_state_q <= DB_RELEASED;
         cnt_q      <= '0;
         pulse_q    <= 1'b0;
      end else begin
         db_state_q <= db_state_d;
         cnt_q      <= cnt_d;
         pulse_q    <= pulse_d;
      end
   end

   // Any sample agreeing with the debounced state restarts qualification, so
   // the count is cleared by default and only advances on a disagreeing sample.
   // Commit clears the count too, so it can never pass CNT_LAST.
   always_comb begin
      db_state_d = db_state_q;
      cnt_d      = '0;
      pulse_d    = 1'b0;
      if (samp_state != db_state_q) begin
         if (cnt_q == CNT_LAST) begin
            db_state_d = samp_state;
            pulse_d    = (samp_state == DB_PRESSED);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse (STABLE_CYCLES=4, active-low button).
// Stimulus pushes the clock edge number at which each pulse must appear;
// a monitor sampling on the falling edge pops and compares every pulse seen.
module tb_debounce_pulse;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn = 1'b1;
   logic btn_pulse;

   int cyc   = 0;
   int n_vec = 0;
   int n_bad = 0;
   int exp_q[$];

   debounce_pulse #(
      .STABLE_CYCLES (4),
      .BTN_ACTIVE_LOW(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .btn_pulse(btn_pulse)
   );

   always #5 clk = ~clk;

   // Edge counter: after rising edge k, cyc == k.
   always @(posedge clk) cyc++;

   // Monitor: every observed pulse must match the oldest expected edge.
   always @(negedge clk) begin
      if (!rst && btn_pulse) begin
         n_vec++;
         n_bad++;
         $display("FAIL pulse_in_reset at edge %0d: got 1, required 0", cyc);
      end else if (btn_pulse) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse at edge %0d: got 1, required 0 (none pending)", cyc);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (e != cyc) begin
               n_bad++;
               $display("FAIL pulse_edge: got edge %0d, required edge %0d", cyc, e);
            end
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0b, required %0b", name, act, req);
      end
   endtask

   // All expected pulses of a scenario must have been consumed by now.
   task automatic check_drained(input string name);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: got %0d pulses still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic bounce(input int n);
      for (int i = 0; i < n; i++) begin
         #3 btn = ~btn;
      end
   endtask

   // Clean press launched just after a falling edge: the first sampling edge
   // is cyc+1, so the pulse lands on edge cyc+1+1+4 = cyc+6.
   task automatic clean_press();
      @(negedge clk);
      btn = 1'b0;
      exp_q.push_back(cyc + 6);
   endtask

   initial begin
      // 1. Reset and idle
      btn = 1'b1;
      rst = 1'b0;
      #3  check_bit("reset_pulse_t3", btn_pulse, 1'b0);
      #10 check_bit("reset_pulse_t13", btn_pulse, 1'b0);
      #7  rst = 1'b1;
      #200;
      check_drained("idle_no_pulse");

      // 2. Bounce then settle released
      @(negedge clk);
      bounce(10);
      btn = 1'b1;
      repeat (10) @(negedge clk);
      check_drained("bounce_released");

      // 3. Clean press, then release
      clean_press();
      repeat (12) @(negedge clk);
      check_drained("clean_press");
      btn = 1'b1;
      repeat (10) @(negedge clk);
      check_drained("clean_release");

      // 4. Bouncy press: bounce, one guaranteed idle sample, then hold low 500 ns
      @(negedge clk);
      bounce(10);
      btn = 1'b1;
      repeat (2) @(negedge clk);
      clean_press();
      #500;
      check_drained("bouncy_press_held");

      // 5. Release bounce, settle released, press again
      @(negedge clk);
      bounce(10);
      btn = 1'b1;
      #100;
      check_drained("release_bounce");
      clean_press();
      repeat (12) @(negedge clk);
      check_drained("repress");
      btn = 1'b1;
      repeat (10) @(negedge clk);

      // 6. Reset mid-count: press sampled at edge E, reset after edge E+2
      @(negedge clk);
      btn = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check_bit("midcount_reset_pulse", btn_pulse, 1'b0);
      repeat (2) @(negedge clk);
      check_bit("midcount_reset_hold", btn_pulse, 1'b0);
      rst = 1'b1;
      exp_q.push_back(cyc + 6);
      repeat (12) @(negedge clk);
      check_drained("requalify_after_reset");

      // 7. Reset mid-pulse drops btn_pulse asynchronously
      btn = 1'b1;
      repeat (10) @(negedge clk);
      @(negedge clk);
      btn = 1'b0;
      repeat (6) @(posedge clk);
      #1 check_bit("pulse_before_reset", btn_pulse, 1'b1);
      rst = 1'b0;
      #1 check_bit("pulse_async_drop", btn_pulse, 1'b0);
      btn = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check_drained("after_midpulse_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
